// File: rtl/spi_flash_target.sv
// SPI NOR-flash responder (standard SPI, mode 0) oversampled in the clk domain.
// Serves READ/FAST READ/PROGRAM/RDSR/WREN/WRDI/CHIP ERASE/RDID from an internal byte array.
module spi_flash_target #(
    parameter int          MEM_BYTES   = 256,
    parameter int          PROG_CYCLES = 64,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       spi_clk,
    input  logic       spi_csn,
    input  logic       spi_sdi0,
    output logic       spi_sdo1,
    output logic       spi_sdo1_oe,
    output logic       wip_o,
    output logic       wel_o,
    output logic       frame_done_o,
    output logic [7:0] cmd_o
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int PW = $clog2(PROG_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_PROG, S_STAT, S_ID, S_IGNORE
    } state_t;

    state_t          state;
    logic [2:0]      sclk_q, csn_q, sdi_q;
    logic [2:0]      bit_cnt;
    logic [1:0]      byte_cnt;
    logic [1:0]      id_idx;
    logic [6:0]      sh_in;
    logic [7:0]      sh_out;
    logic [AW-1:0]   addr;
    logic            erase_armed, prog_stored;
    logic            prog_busy, erase_busy;
    logic [PW-1:0]   prog_cnt;
    logic [AW-1:0]   erase_ptr;
    logic [7:0]      mem [MEM_BYTES];

    // Stage [1] is the synchronized level, stage [2] the previous one for edge detect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_q <= 3'b000;
            csn_q  <= 3'b111;
            sdi_q  <= 3'b000;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            csn_q  <= {csn_q[1:0], spi_csn};
            sdi_q  <= {sdi_q[1:0], spi_sdi0};
        end
    end

    logic          cs_rise, cs_fall, sck_rise, sck_fall, mosi, byte_end, tx_state;
    logic [7:0]    rx_byte, status, id_byte;
    logic [AW-1:0] addr_nxt;

    assign cs_rise  = csn_q[1] & ~csn_q[2];
    assign cs_fall  = ~csn_q[1] & csn_q[2];
    assign sck_rise = sclk_q[1] & ~sclk_q[2];
    assign sck_fall = ~sclk_q[1] & sclk_q[2];
    // MOSI value aligned with the sclk sample preceding the detected rise.
    assign mosi     = sdi_q[2];
    assign rx_byte  = {sh_in, mosi};
    assign byte_end = sck_rise && (bit_cnt == 3'd7);
    assign addr_nxt = {addr[AW-2:0], mosi};
    assign status   = {6'b0, wel_o, wip_o};
    assign tx_state = (state == S_READ) || (state == S_STAT) || (state == S_ID);

    always_comb begin
        case (id_idx)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            default: id_byte = JEDEC_ID[7:0];
        endcase
    end

    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [7:0]    mem_wd;

    // Erase and program never overlap: any PROGRAM while WIP is ignored.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = addr;
        mem_wd = mem[addr] & rx_byte;
        if (erase_busy) begin
            mem_we = 1'b1;
            mem_wa = erase_ptr;
            mem_wd = 8'hFF;
        end else if (state == S_PROG && byte_end && !cs_rise) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            bit_cnt      <= 3'd0;
            byte_cnt     <= 2'd0;
            id_idx       <= 2'd0;
            sh_in        <= 7'd0;
            sh_out       <= 8'd0;
            addr         <= '0;
            spi_sdo1     <= 1'b0;
            spi_sdo1_oe  <= 1'b0;
            wip_o        <= 1'b0;
            wel_o        <= 1'b0;
            frame_done_o <= 1'b0;
            cmd_o        <= 8'd0;
            erase_armed  <= 1'b0;
            prog_stored  <= 1'b0;
            prog_busy    <= 1'b0;
            prog_cnt     <= '0;
            erase_busy   <= 1'b0;
            erase_ptr    <= '0;
        end else begin
            frame_done_o <= 1'b0;

            if (prog_busy) begin
                if (prog_cnt == '0) begin
                    prog_busy <= 1'b0;
                    wip_o     <= 1'b0;
                    wel_o     <= 1'b0;
                end else begin
                    prog_cnt <= prog_cnt - 1'b1;
                end
            end
            if (erase_busy) begin
                if (erase_ptr == AW'(MEM_BYTES - 1)) begin
                    erase_busy <= 1'b0;
                    wip_o      <= 1'b0;
                    wel_o      <= 1'b0;
                end else begin
                    erase_ptr <= erase_ptr + 1'b1;
                end
            end

            if (cs_rise) begin
                state        <= S_IDLE;
                bit_cnt      <= 3'd0;
                spi_sdo1_oe  <= 1'b0;
                frame_done_o <= 1'b1;
                erase_armed  <= 1'b0;
                prog_stored  <= 1'b0;
                if (state == S_PROG && prog_stored) begin
                    wip_o     <= 1'b1;
                    prog_busy <= 1'b1;
                    prog_cnt  <= PW'(PROG_CYCLES - 1);
                end
                if (erase_armed) begin
                    wip_o      <= 1'b1;
                    erase_busy <= 1'b1;
                    erase_ptr  <= '0;
                end
            end else if (state == S_IDLE) begin
                if (cs_fall) begin
                    state    <= S_CMD;
                    bit_cnt  <= 3'd0;
                    byte_cnt <= 2'd0;
                end
            end else begin
                if (sck_rise) begin
                    sh_in   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (state == S_ADDR) addr <= addr_nxt;
                end
                if (sck_fall && tx_state) begin
                    spi_sdo1    <= sh_out[7];
                    sh_out      <= {sh_out[6:0], 1'b0};
                    spi_sdo1_oe <= 1'b1;
                end
                if (byte_end) begin
                    case (state)
                        S_CMD: begin
                            cmd_o    <= rx_byte;
                            byte_cnt <= 2'd0;
                            state    <= S_IGNORE;
                            if (!(wip_o && rx_byte != 8'h05)) begin
                                case (rx_byte)
                                    8'h03, 8'h0B: state <= S_ADDR;
                                    8'h02: if (wel_o) state <= S_ADDR;
                                    8'h05: begin
                                        state  <= S_STAT;
                                        sh_out <= status;
                                    end
                                    8'h06: wel_o <= 1'b1;
                                    8'h04: wel_o <= 1'b0;
                                    8'hC7: erase_armed <= wel_o;
                                    8'h9F: begin
                                        state  <= S_ID;
                                        sh_out <= JEDEC_ID[23:16];
                                        id_idx <= 2'd1;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                        S_ADDR: begin
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd2) begin
                                case (cmd_o)
                                    8'h03: begin
                                        state  <= S_READ;
                                        sh_out <= mem[addr_nxt];
                                        addr   <= addr_nxt + 1'b1;
                                    end
                                    8'h0B:   state <= S_DUMMY;
                                    default: state <= S_PROG;
                                endcase
                            end
                        end
                        S_DUMMY, S_READ: begin
                            state  <= S_READ;
                            sh_out <= mem[addr];
                            addr   <= addr + 1'b1;
                        end
                        S_PROG: begin
                            addr        <= addr + 1'b1;
                            prog_stored <= 1'b1;
                        end
                        S_STAT: sh_out <= status;
                        S_ID: begin
                            sh_out <= id_byte;
                            id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_target.sv
// Directed bench for spi_flash_target: bit-banged SPI frames with hand-computed expectations.
module tb_spi_flash_target;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_sdi0 = 1'b0;
    logic       spi_sdo1, spi_sdo1_oe, wip_o, wel_o, frame_done_o;
    logic [7:0] cmd_o;

    int   checks = 0;
    int   errors = 0;
    logic oe_seen = 1'b0;
    int   fd_cnt = 0;
    int   wip_run = 0;
    int   wip_last = 0;
    int   wip_rises = 0;
    logic wip_q = 1'b0;

    spi_flash_target #(.MEM_BYTES(256), .PROG_CYCLES(64), .JEDEC_ID(24'hEF4016)) dut (
        .clk(clk), .rstn(rstn), .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_sdi0(spi_sdi0),
        .spi_sdo1(spi_sdo1), .spi_sdo1_oe(spi_sdo1_oe), .wip_o(wip_o), .wel_o(wel_o),
        .frame_done_o(frame_done_o), .cmd_o(cmd_o)
    );

    always #5 clk = ~clk;

    // Track WIP run lengths, WIP rising edges and frame_done pulses.
    always @(posedge clk) begin
        wip_q <= wip_o;
        if (wip_o && !wip_q) wip_rises <= wip_rises + 1;
        if (wip_o) wip_run <= wip_run + 1;
        else begin
            if (wip_run != 0) wip_last <= wip_run;
            wip_run <= 0;
        end
        if (frame_done_o) fd_cnt <= fd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_sdi0 = tx[7-i];
            repeat (4) @(negedge clk);
            rx = {rx[6:0], spi_sdo1};
            if (spi_sdo1_oe) oe_seen = 1'b1;
            spi_clk = 1'b1;
            repeat (8) @(negedge clk);
            spi_clk = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] r;
        spi_bits(b, 8, r);
    endtask

    task automatic send_addr(input logic [23:0] a);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
    endtask

    task automatic recv(input int n, output logic [31:0] d);
        logic [7:0] r;
        d = 32'h0;
        for (int i = 0; i < n; i++) begin
            spi_bits(8'h00, 8, r);
            d = {d[23:0], r};
        end
    endtask

    task automatic begin_frame();
        spi_csn = 1'b0;
        oe_seen = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (4) @(negedge clk);
        spi_csn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic one_byte_cmd(input logic [7:0] c);
        begin_frame();
        send(c);
        end_frame();
    endtask

    task automatic rd(input logic [23:0] a, input int n, output logic [31:0] d);
        begin_frame();
        send(8'h03);
        send_addr(a);
        recv(n, d);
        end_frame();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (wip_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 2000), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  r;
        int          f0, r0;

        repeat (3) @(negedge clk);
        chk("rst_sdo", 32'(spi_sdo1), 0);
        chk("rst_oe", 32'(spi_sdo1_oe), 0);
        chk("rst_wip", 32'(wip_o), 0);
        chk("rst_wel", 32'(wel_o), 0);
        chk("rst_fd", 32'(frame_done_o), 0);
        chk("rst_cmd", 32'(cmd_o), 0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // WREN, chip erase, status polling during and after the erase walk
        one_byte_cmd(8'h06);
        chk("wren_wel", 32'(wel_o), 1);
        one_byte_cmd(8'hC7);
        begin_frame();
        send(8'h05);
        recv(3, d);
        end_frame();
        chk("rdsr_busy", 32'(d[23:16]), 32'h03);
        chk("rdsr_done", 32'(d[7:0]), 32'h00);
        wait_idle("erase_timeout");
        chk("erase_wip_len", 32'(wip_last), 256);
        chk("erase_wel", 32'(wel_o), 0);
        rd(24'h000010, 4, d);
        chk("erased_read", d, 32'hFFFFFFFF);

        // Page program across the top of the array, wrapping to 0x00
        one_byte_cmd(8'h06);
        begin_frame();
        send(8'h02);
        send_addr(24'h0000FE);
        send(8'hA5);
        send(8'h5A);
        send(8'h3C);
        end_frame();
        wait_idle("prog_timeout");
        chk("prog_wip_len", 32'(wip_last), 64);
        chk("prog_wel", 32'(wel_o), 0);
        rd(24'h0000FE, 3, d);
        chk("prog_read_wrap", d, 32'h00A55A3C);

        // AND semantics on reprogram
        one_byte_cmd(8'h06);
        begin_frame();
        send(8'h02);
        send_addr(24'h0000FE);
        send(8'h0F);
        end_frame();
        wait_idle("and_timeout");
        rd(24'h0000FE, 1, d);
        chk("prog_and", d, 32'h05);

        // PROGRAM without WREN does nothing
        r0 = wip_rises;
        begin_frame();
        send(8'h02);
        send_addr(24'h000010);
        send(8'h00);
        end_frame();
        repeat (80) @(negedge clk);
        chk("nowel_wip", 32'(wip_rises - r0), 0);
        rd(24'h000010, 1, d);
        chk("nowel_mem", d, 32'hFF);

        // FAST READ matches plain READ; no drive during cmd/addr/dummy
        begin_frame();
        send(8'h0B);
        send_addr(24'h000000);
        send(8'h00);
        chk("fast_oe_quiet", 32'(oe_seen), 0);
        recv(2, d);
        end_frame();
        chk("fast_read", d, 32'h3CFF);
        rd(24'h000000, 2, d);
        chk("plain_read", d, 32'h3CFF);

        // RDID repeats the JEDEC bytes
        begin_frame();
        send(8'h9F);
        recv(4, d);
        end_frame();
        chk("rdid", d, 32'hEF4016EF);

        // Unknown command: no drive, cmd_o latched, one frame_done pulse
        f0 = fd_cnt;
        begin_frame();
        send(8'hAB);
        recv(2, d);
        end_frame();
        chk("unk_oe", 32'(oe_seen), 0);
        chk("unk_cmd", 32'(cmd_o), 32'hAB);
        chk("unk_fd", 32'(fd_cnt - f0), 1);

        // Partial program byte is discarded; WEL kept since nothing stored
        one_byte_cmd(8'h06);
        r0 = wip_rises;
        begin_frame();
        send(8'h02);
        send_addr(24'h000020);
        spi_bits(8'h00, 5, r);
        end_frame();
        repeat (80) @(negedge clk);
        chk("partial_wip", 32'(wip_rises - r0), 0);
        chk("partial_wel", 32'(wel_o), 1);
        rd(24'h000020, 1, d);
        chk("partial_mem", d, 32'hFF);
        one_byte_cmd(8'h04);
        chk("wrdi_wel", 32'(wel_o), 0);

        // Reset in the middle of a read frame
        one_byte_cmd(8'h06);
        begin_frame();
        send(8'h03);
        send_addr(24'h000000);
        recv(1, d);
        chk("mid_read", d, 32'h3C);
        chk("mid_oe", 32'(spi_sdo1_oe), 1);
        rstn = 1'b0;
        @(negedge clk);
        chk("mrst_sdo", 32'(spi_sdo1), 0);
        chk("mrst_oe", 32'(spi_sdo1_oe), 0);
        chk("mrst_wel", 32'(wel_o), 0);
        chk("mrst_wip", 32'(wip_o), 0);
        chk("mrst_fd", 32'(frame_done_o), 0);
        chk("mrst_cmd", 32'(cmd_o), 0);
        spi_csn = 1'b1;
        spi_clk = 1'b0;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        begin_frame();
        send(8'h9F);
        recv(1, d);
        end_frame();
        chk("post_rst_rdid", d, 32'hEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
